full_subtractor: RTL and testbench

- Registered, width-parameterised full subtractor: computes a − b − borrow_in, producing difference d and borrow_out.
- Built as a ripple-borrow chain of 1-bit full-subtractor cells, with a single output register stage and a valid flag.
- With WIDTH=1 it is the single-bit full-subtractor primitive used by the arithmetic-circuit library.
- Sits inside larger datapaths (ALU subtract path, comparators, decrementers).

---
 rtl/full_subtractor.sv | 61 ++++++
 tb/tb_full_subtractor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/full_subtractor.sv
// Registered ripple-borrow full subtractor: d = a - b - borrow_in, one-cycle latency.
// WIDTH=1 yields the single-bit full-subtractor primitive.

module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

module full_subtractor #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] d,
  output logic             borrow_out,
  output logic             out_valid
);

  logic [WIDTH:0]   borrow;
  logic [WIDTH-1:0] diff;

  assign borrow[0] = borrow_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_subtractor_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (borrow[i]),
      .d    (diff[i]),
      .bout (borrow[i+1])
    );
  end

  // Result registers only load on valid input, so idle (possibly X) operands never reach d/borrow_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d          <= '0;
      borrow_out <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        d          <= diff;
        borrow_out <= borrow[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_full_subtractor.sv
// Directed and reference-checked bench for full_subtractor at WIDTH=1 and WIDTH=8.
module tb_full_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v1, a1, b1, bi1;
  logic       d1, bo1, ov1;
  logic       v8, bi8;
  logic [7:0] a8, b8;
  logic [7:0] d8;
  logic       bo8, ov8;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  full_subtractor #(.WIDTH(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (v1),
    .a          (a1),
    .b          (b1),
    .borrow_in  (bi1),
    .d          (d1),
    .borrow_out (bo1),
    .out_valid  (ov1)
  );

  full_subtractor #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (v8),
    .a          (a8),
    .b          (b8),
    .borrow_in  (bi8),
    .d          (d8),
    .borrow_out (bo8),
    .out_valid  (ov8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {a, b, bin, d, bout}
  logic [4:0] vec1 [8];
  // {a, b, bin, d, bout}
  logic [25:0] vec8 [5];

  initial begin
    logic [8:0] ref9;

    vec1 = '{5'b000_00, 5'b001_11, 5'b010_11, 5'b011_01,
             5'b100_10, 5'b101_00, 5'b110_00, 5'b111_11};
    vec8 = '{{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1},
             {8'h80, 8'h01, 1'b0, 8'h7F, 1'b0},
             {8'h55, 8'h55, 1'b1, 8'hFF, 1'b1},
             {8'h55, 8'h55, 1'b0, 8'h00, 1'b0},
             {8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0}};

    v1 = 0; a1 = 0; b1 = 0; bi1 = 0;
    v8 = 0; a8 = 0; b8 = 0; bi8 = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset_d1",  64'(d1),  64'd0);
    check("reset_bo1", 64'(bo1), 64'd0);
    check("reset_ov1", 64'(ov1), 64'd0);
    check("reset_d8",  64'(d8),  64'd0);
    check("reset_ov8", 64'(ov8), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 exhaustive sweep
    for (int i = 0; i < 8; i++) begin
      {a1, b1, bi1} = vec1[i][4:2];
      v1 = 1'b1;
      tick();
      check($sformatf("sweep%0d_d", i),  64'(d1),  64'(vec1[i][1]));
      check($sformatf("sweep%0d_bo", i), 64'(bo1), 64'(vec1[i][0]));
      check($sformatf("sweep%0d_ov", i), 64'(ov1), 64'd1);
    end

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_d1",  64'(d1),  64'd0);
    check("async_rst_bo1", 64'(bo1), 64'd0);
    check("async_rst_ov1", 64'(ov1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a1 = 1; b1 = 0; bi1 = 0; v1 = 1;
    tick();
    check("post_rst_d1",  64'(d1),  64'd1);
    check("post_rst_bo1", 64'(bo1), 64'd0);
    check("post_rst_ov1", 64'(ov1), 64'd1);

    // Hold
    a1 = 1; b1 = 1; bi1 = 1;
    tick();
    check("hold_cap_d1",  64'(d1),  64'd1);
    check("hold_cap_bo1", 64'(bo1), 64'd1);
    v1 = 0; a1 = 0; b1 = 0; bi1 = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold%0d_d1", i),  64'(d1),  64'd1);
      check($sformatf("hold%0d_bo1", i), 64'(bo1), 64'd1);
      check($sformatf("hold%0d_ov1", i), 64'(ov1), 64'd0);
    end

    // WIDTH=8 boundaries
    for (int i = 0; i < 5; i++) begin
      {a8, b8, bi8} = vec8[i][25:9];
      v8 = 1'b1;
      tick();
      check($sformatf("bnd%0d_d8", i),  64'(d8),  64'(vec8[i][8:1]));
      check($sformatf("bnd%0d_bo8", i), 64'(bo8), 64'(vec8[i][0]));
      check($sformatf("bnd%0d_ov8", i), 64'(ov8), 64'd1);
    end

    // Idle with unknown operands must not disturb held result (last: 0xFF, 0)
    v8 = 0; a8 = 'x; b8 = 'x; bi8 = 1'bx;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("xhold%0d_d8", i),  64'(d8),  64'hFF);
      check($sformatf("xhold%0d_bo8", i), 64'(bo8), 64'd0);
      check($sformatf("xhold%0d_ov8", i), 64'(ov8), 64'd0);
    end

    // WIDTH=8 random back-to-back stream
    for (int i = 0; i < 1000; i++) begin
      a8  = 8'($urandom_range(0, 255));
      b8  = 8'($urandom_range(0, 255));
      bi8 = 1'($urandom_range(0, 1));
      v8  = 1'b1;
      ref9 = {1'b0, a8} - {1'b0, b8} - {8'd0, bi8};
      tick();
      check("rand_d8",  64'(d8),  64'(ref9[7:0]));
      check("rand_bo8", 64'(bo8), 64'(ref9[8]));
      check("rand_ov8", 64'(ov8), 64'd1);
    end

    // Mid-stream reset: results in flight are discarded
    a8 = 8'h12; b8 = 8'h34; bi8 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_d8",  64'(d8),  64'd0);
    check("mid_rst_bo8", 64'(bo8), 64'd0);
    check("mid_rst_ov8", 64'(ov8), 64'd0);
    tick();
    check("mid_rst_edge_d8",  64'(d8),  64'd0);
    check("mid_rst_edge_ov8", 64'(ov8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a8 = 8'h10; b8 = 8'h03; bi8 = 1'b1;
    tick();
    check("mid_rel_d8",  64'(d8),  64'h0C);
    check("mid_rel_bo8", 64'(bo8), 64'd0);
    check("mid_rel_ov8", 64'(ov8), 64'd1);
    a8 = 8'h03; b8 = 8'h10; bi8 = 1'b0;
    tick();
    check("mid_next_d8",  64'(d8),  64'hF3);
    check("mid_next_bo8", 64'(bo8), 64'd1);
    v8 = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
